// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S PCM transmitter.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } tx_state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SLOT_BITS  = 32;
    localparam int DEF_CLK_DIV    = 8;

    function automatic int bit_cnt_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

endpackage

// File: rtl/i2s_pcm_tx_if.sv
// PCM sample stream into the I2S transmitter: valid/ready handshake.
interface i2s_pcm_tx_if
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] pcm_in;
    logic                  pcm_valid;
    logic                  pcm_ready;

    modport master (output pcm_in, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_in, input pcm_valid, output pcm_ready);

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every CLK_DIV system clocks while run is high.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic fall_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          half_done;

    assign half_done = run && (div_cnt_q == DIV_LAST);
    assign fall_tick = half_done && bclk_q;
    assign bclk      = bclk_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (!run) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (half_done) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_pcm_tx.sv
// I2S master transmitter: one-entry PCM holding register, slot loader and
// serialiser. All serial outputs change on BCLK falling edges.
module i2s_pcm_tx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_BITS  = DEF_SLOT_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter bit STEREO_DUP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    i2s_pcm_tx_if.slave pcm,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam int BW = bit_cnt_width(SLOT_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DATA_LEN = BW'(DATA_WIDTH);

    tx_state_t                    state_q, state_d;
    logic [BW-1:0]                bit_cnt_q, bit_cnt_d, bit_nxt, pos_nxt;
    logic signed [DATA_WIDTH-1:0] hold_q, hold_d, samp_q, samp_d, shreg_q, shreg_d;
    logic                         hold_full_q, hold_full_d;
    logic                         lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                         frame_start_q, frame_start_d, underrun_q, underrun_d;
    logic                         run, fall_tick, load;

    assign run = (state_q != IDLE);

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .bclk      (i2s_bclk),
        .fall_tick (fall_tick)
    );

    assign bit_nxt = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    assign pos_nxt = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        samp_d        = samp_q;
        shreg_d       = shreg_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = underrun_q & ~underrun_clr;
        load          = 1'b0;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                lrclk_d   = 1'b0;
                sdata_d   = 1'b0;
                if (enable) begin
                    state_d       = RUN;
                    load          = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            RUN, STOP: begin
                state_d = enable ? RUN : STOP;
                if (fall_tick) begin
                    bit_cnt_d = bit_nxt;
                    lrclk_d   = (bit_nxt >= SLOT_LEN);
                    // Position 0 is the one-BCLK I2S delay slot; data follows MSB first.
                    if ((pos_nxt != '0) && (pos_nxt <= DATA_LEN)) begin
                        sdata_d = shreg_q[DATA_WIDTH-1];
                        shreg_d = shreg_q << 1;
                    end else begin
                        sdata_d = 1'b0;
                    end
                    if (bit_nxt == '0) begin
                        if (!enable && state_q == STOP) begin
                            state_d = IDLE;
                        end else begin
                            load          = 1'b1;
                            frame_start_d = 1'b1;
                        end
                    end else if (bit_nxt == SLOT_LEN) begin
                        if (STEREO_DUP) shreg_d = samp_q;
                        else            load    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                samp_d      = hold_q;
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                samp_d     = '0;
                shreg_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // Ready is low while full, so an accept never overlaps a consume of the same entry.
        if (pcm.pcm_valid && !hold_full_q) begin
            hold_d      = pcm.pcm_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            samp_q        <= '0;
            shreg_q       <= '0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            samp_q        <= samp_d;
            shreg_q       <= shreg_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pcm.pcm_ready = ~hold_full_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_sdata     = sdata_q;
    assign frame_start   = frame_start_q;
    assign underrun      = underrun_q;

endmodule

// File: doc/i2s_pcm_tx.md
Name: i2s_pcm_tx

Overview:
I2S transmitter, the transmit-side counterpart of the microphone capture path. It accepts 16-bit PCM samples over a valid/ready handshake and serialises them as a standard I2S stream, acting as clock master and driving BCLK, LRCLK and SDATA. The stream either feeds an external DAC or loops back into the microphone receive input as a stimulus source for on-board self-test. It sits on the same 25 MHz system clock as the capture and SPI logic.

Parameters:
DATA_WIDTH, 16, PCM sample width; must satisfy DATA_WIDTH <= SLOT_BITS-1.
SLOT_BITS, 32, BCLK periods per channel slot; one frame is 2*SLOT_BITS.
CLK_DIV, 8, system clocks per BCLK half-period; must be >= 2. BCLK = clk/(2*CLK_DIV).
STEREO_DUP, 1, 1: one sample per frame, sent on both channels. 0: one sample per slot, left then right.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  start/stop request, level-sensitive
pcm_in  in  DATA_WIDTH  sample, two's complement
pcm_valid  in  1  pcm_in valid
pcm_ready  out  1  holding register empty
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select: 0 = left, 1 = right
i2s_sdata  out  1  serial data, MSB first
frame_start  out  1  one-cycle pulse at each frame load
underrun  out  1  sticky underrun flag
underrun_clr  in  1  clears underrun

Behaviour:
- Reset (async, rst_n=0): state IDLE; i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame_start=0, underrun=0; holding register empty (pcm_ready=1); all counters 0.
- Holding register: one entry. Accept on pcm_valid && pcm_ready. pcm_ready = !hold_full, derived from a register. Accept and consume never collide, because ready is 0 whenever hold is full. The holding register is retained across IDLE.
- Slot load: copy hold into the shift register and empty hold. If hold is empty, load zeros and set underrun. In STEREO_DUP=1 a load happens only at left-slot start, and the right slot reuses the same sample. In STEREO_DUP=0 a load happens at every slot start.
- State IDLE: all I2S outputs 0. When enable=1, move to RUN the next cycle and in that cycle:
  - set div_cnt=0 and bit_cnt=0;
  - perform a left-slot load;
  - pulse frame_start.
- State RUN:
  - div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1, i2s_bclk toggles and div_cnt returns to 0.
  - A 1->0 BCLK toggle is a fall tick. On each fall tick, bit_cnt increments modulo 2*SLOT_BITS.
  - All output updates happen on fall ticks, so the receiver samples on the rising edge.
  - Slot position p = bit_cnt mod SLOT_BITS; i2s_lrclk = (bit_cnt >= SLOT_BITS).
  - i2s_sdata = 0 at p=0; sample bit DATA_WIDTH-p for p = 1..DATA_WIDTH (MSB at p=1); 0 for p > DATA_WIDTH. This gives the standard one-BCLK I2S delay.
  - When bit_cnt wraps to 0: left-slot load and frame_start pulse. When bit_cnt reaches SLOT_BITS: right-slot load (STEREO_DUP=0 only).
  - If enable=0, move to STOP.
- State STOP: behaves as RUN until the fall tick where bit_cnt wraps to 0. At that tick, go to IDLE and drive all outputs to 0. No load and no frame_start occur. If enable returns to 1 in STOP, go back to RUN with no glitch.
- Timing: the left MSB appears on i2s_sdata 2*CLK_DIV cycles after frame_start. A frame lasts 4*SLOT_BITS*CLK_DIV cycles (1024 at defaults).
- underrun: set on an empty-hold load; cleared by underrun_clr. If set and clear happen in the same cycle, set wins.
- Reset mid-frame: outputs return to 0 immediately and hold is emptied.

Decomposition:
- Package i2s_pkg holds:
  - tx_state_t enum: IDLE, RUN, STOP;
  - default constants for DATA_WIDTH, SLOT_BITS, CLK_DIV;
  - a bit-counter width function ($clog2(2*SLOT_BITS)).
- Sub-module i2s_bclk_gen contains the divider. It outputs bclk and fall_tick, and takes a run input that holds it at bclk=0, div_cnt=0.

Test Plan:
1. STEREO_DUP=1: push 16'hA5C3, then enable. Sample sdata on BCLK rise: left p1..16 = A5C3, right p1..16 = A5C3, all other positions 0. frame_start fires once per 1024 clocks.
2. STEREO_DUP=0: push 16'h1234 and 16'hABCD. Left slot = 1234, right slot = ABCD, with pcm_ready=0 between loads as back-pressure.
3. Enable with hold empty: both slots are all-zero and underrun=1. Pulse underrun_clr: underrun returns to 0. Set and clear in the same cycle leaves underrun=1.
4. Push 2 samples back to back. The second waits with pcm_ready=0 until the next frame_start, then is accepted within 1 cycle.
5. Drop enable at bit 10 of the left slot: the frame completes, the state goes to IDLE exactly at the wrap, all outputs are 0 and no extra frame_start occurs.
6. Assert rst_n=0 mid-frame: outputs are 0 asynchronously and pcm_ready=1. After release with enable=1, a fresh frame starts with lrclk=0.
